pixel_combinator: RTL and testbench

PIXEL_COMBINATOR -- requirements
Module: pixel_combinator

---
 rtl/pixel_pkg.sv | 17 +
 rtl/pixel_combinator_lane_arbiter.sv | 23 ++
 rtl/pixel_combinator.sv | 129 ++++++++++++
 tb/tb_pixel_combinator.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and default widths for the pixel combinator.
package pixel_pkg;

  localparam int PIXEL_DATA_WIDTH = 10;
  localparam int RBG_SIZE         = 24;

  typedef logic [PIXEL_DATA_WIDTH-1:0] coord_t;
  typedef logic [RBG_SIZE-1:0]         colour_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } combinator_state_t;

endpackage

// File: rtl/pixel_combinator_lane_arbiter.sv
// Combinational lowest-index-wins select across engine lanes, with multi-hit flag.
module lane_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int COLOUR_W  = 24
) (
  input  logic [NUM_LANES-1:0][COLOUR_W-1:0] colour,
  input  logic [NUM_LANES-1:0]               hit,
  output logic                               any_hit,
  output logic [COLOUR_W-1:0]                sel_colour,
  output logic                               multi_hit
);

  always_comb begin
    any_hit    = |hit;
    sel_colour = '0;
    // Scan from the top so the lowest set index is the last writer.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (hit[i]) sel_colour = colour[i];
    end
    multi_hit = |(hit & (hit - NUM_LANES'(1)));
  end

endmodule

// File: rtl/pixel_combinator.sv
// Raster-order pixel requester/collector feeding a valid/ready pixel stream.
// Optional miss watchdog enabled by defining COMBINATOR_TIMEOUT_EN.
module pixel_combinator
  import pixel_pkg::combinator_state_t, pixel_pkg::ST_IDLE, pixel_pkg::ST_ISSUE,
         pixel_pkg::ST_CAPTURE, pixel_pkg::ST_HOLD;
#(
  parameter int NUM_LANES        = 4,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int RBG_SIZE         = 24,
  parameter int FRAME_W          = 640,
  parameter int FRAME_H          = 480,
  parameter int TIMEOUT          = 1023
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
  input  logic [NUM_LANES-1:0][RBG_SIZE-1:0]  colour_i,
  input  logic [NUM_LANES-1:0]                hit_i,
  output logic [PIXEL_DATA_WIDTH-1:0]         xpixel_check,
  output logic [PIXEL_DATA_WIDTH-1:0]         ypixel_check,
  output logic [RBG_SIZE-1:0]                 pix_data,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic                                pix_sop,
  output logic                                pix_eop,
  output logic                                frame_done,
  output logic                                dup_err,
`ifdef COMBINATOR_TIMEOUT_EN
  output logic                                timeout_err,
`endif
  output combinator_state_t                   fsm_state
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(FRAME_W - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(FRAME_H - 1);

  combinator_state_t state, state_next;
  logic [PIXEL_DATA_WIDTH-1:0] x, y;
  logic any_hit, multi_hit, in_capture, drain, out_free, take, timed_out;
  logic [RBG_SIZE-1:0] sel_colour, take_colour;

  lane_arbiter #(
    .NUM_LANES (NUM_LANES),
    .COLOUR_W  (RBG_SIZE)
  ) u_arb (
    .colour     (colour_i),
    .hit        (hit_i),
    .any_hit    (any_hit),
    .sel_colour (sel_colour),
    .multi_hit  (multi_hit)
  );

  // Stream handshake: a beat transfers on a cycle where pix_valid && pix_ready;
  // pix_data/sop/eop are held unchanged while pix_valid && !pix_ready.
  assign drain      = pix_valid & pix_ready;
  assign out_free   = ~pix_valid | drain;
  assign in_capture = (state == ST_CAPTURE);
  assign frame_done = drain & pix_eop;
  assign fsm_state  = state;

  assign xpixel_check = (state == ST_ISSUE) ? x : '1;
  assign ypixel_check = (state == ST_ISSUE) ? y : '1;

`ifdef COMBINATOR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TMO_W-1:0] miss_count;

  assign timed_out = in_capture & ~any_hit & (miss_count == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_count  <= '0;
      timeout_err <= 1'b0;
    end else if (in_capture) begin
      miss_count <= (any_hit | timed_out) ? '0 : miss_count + TMO_W'(1);
      if (timed_out) timeout_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // A watchdog expiry stands in for a hit carrying black.
  assign take        = in_capture & (any_hit | timed_out);
  assign take_colour = any_hit ? sel_colour : '0;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (!run) state_next = ST_HOLD;
                  else if (out_free) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = take ? ST_IDLE : ST_ISSUE;
      ST_HOLD:    if (run) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_sop   <= 1'b0;
      pix_eop   <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (take) begin
        pix_valid <= 1'b1;
        pix_data  <= take_colour;
        pix_sop   <= (x == '0) && (y == '0);
        pix_eop   <= (x == X_LAST) && (y == Y_LAST);
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + PIXEL_DATA_WIDTH'(1);
        end else begin
          x <= x + PIXEL_DATA_WIDTH'(1);
        end
      end else if (drain) begin
        pix_valid <= 1'b0;
      end
      if ((in_capture & multi_hit) | (~in_capture & (|hit_i))) dup_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_combinator.sv
// Self-checking bench for pixel_combinator on a 4x2 frame with two lanes.
module tb_pixel_combinator;
  import pixel_pkg::*;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int NL = 2;
  localparam int PW = 10;
  localparam int CW = 24;
  localparam int TB_TIMEOUT = 5;

  logic                   clk, reset, run, pix_ready;
  logic [NL-1:0][CW-1:0]  colour_i;
  logic [NL-1:0]          hit_i;
  logic [PW-1:0]          xpixel_check, ypixel_check;
  logic [CW-1:0]          pix_data;
  logic                   pix_valid, pix_sop, pix_eop, frame_done, dup_err;
`ifdef COMBINATOR_TIMEOUT_EN
  logic                   timeout_err;
`endif
  combinator_state_t      fsm_state;

  pixel_combinator #(
    .NUM_LANES(NL), .PIXEL_DATA_WIDTH(PW), .RBG_SIZE(CW),
    .FRAME_W(FW), .FRAME_H(FH), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .colour_i(colour_i), .hit_i(hit_i),
    .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sop(pix_sop), .pix_eop(pix_eop), .frame_done(frame_done), .dup_err(dup_err),
`ifdef COMBINATOR_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // scoreboard: {sop, eop, colour}
  logic [CW+1:0] exp_q[$];

  // reference model of the requester and lanes
  int            next_idx, consec_miss, beats, frames, issues, target_issues;
  bit            req_pending, rand_colour, target_double;
  int            target_idx, target_misses, target_lane, rand_miss_pct;
  logic [CW-1:0] target_colour, target_colour2, last_data;
  logic [PW-1:0] last_req_x, last_req_y;

  function automatic logic [CW-1:0] ref_colour(input int idx);
    int px, py;
    px = idx % FW;
    py = (idx / FW) % FH;
    return CW'(16 * py + px);
  endfunction

  function automatic logic ref_sop(input int idx);
    return (idx % (FW * FH)) == 0;
  endfunction

  function automatic logic ref_eop(input int idx);
    return (idx % (FW * FH)) == (FW * FH - 1);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    next_idx = 0; consec_miss = 0; beats = 0; frames = 0; issues = 0;
    target_issues = 0; req_pending = 0; rand_colour = 0; target_double = 0;
    target_idx = -1; target_misses = 0; target_lane = 0; rand_miss_pct = 0;
    last_data = '0; last_req_x = '1; last_req_y = '1;
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; hit_i = '0; colour_i = '0; pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // One cycle: answer last cycle's request, drive ready, then observe.
  task automatic step(input logic rdy);
    logic [CW-1:0] c;
    logic [CW+1:0] e;
    int lane;
    bit miss;
    @(posedge clk);
    #1;
    hit_i = '0;
    colour_i = '0;
    if (req_pending) begin
      miss = 0;
      if (next_idx == target_idx && target_misses > 0) begin
        target_misses--;
        miss = 1;
      end else if (next_idx != target_idx && $urandom_range(0, 99) < rand_miss_pct) begin
        miss = 1;
      end
      if (miss) begin
        consec_miss++;
`ifdef COMBINATOR_TIMEOUT_EN
        if (consec_miss == TB_TIMEOUT) begin
          exp_q.push_back({ref_sop(next_idx), ref_eop(next_idx), {CW{1'b0}}});
          next_idx++;
          consec_miss = 0;
        end
`endif
      end else begin
        consec_miss = 0;
        c = rand_colour ? CW'($urandom) : ref_colour(next_idx);
        lane = $urandom_range(0, NL - 1);
        if (next_idx == target_idx) begin
          c = target_colour;
          lane = target_lane;
        end
        if (next_idx == target_idx && target_double) begin
          hit_i = '1;
          colour_i[0] = c;
          colour_i[1] = target_colour2;
        end else begin
          hit_i[lane] = 1'b1;
          colour_i[lane] = c;
        end
        exp_q.push_back({ref_sop(next_idx), ref_eop(next_idx), c});
        next_idx++;
      end
    end
    pix_ready = rdy;
    #1;
    req_pending = (xpixel_check !== '1);
    total++;
    if (req_pending) begin
      issues++;
      if (next_idx == target_idx) target_issues++;
      last_req_x = xpixel_check;
      last_req_y = ypixel_check;
      if (xpixel_check !== PW'(next_idx % FW) || ypixel_check !== PW'((next_idx / FW) % FH)) begin
        $display("FAIL request_coord: got (%0d,%0d) expected (%0d,%0d)", xpixel_check,
                 ypixel_check, next_idx % FW, (next_idx / FW) % FH);
      end else passed++;
    end else begin
      if (ypixel_check !== '1) $display("FAIL idle_y_check: got %h expected all-ones", ypixel_check);
      else passed++;
    end
    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      beats++;
      last_data = pix_data;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got %h with nothing expected", pix_data);
      end else begin
        e = exp_q.pop_front();
        if ({pix_sop, pix_eop, pix_data} !== e)
          $display("FAIL beat: got sop=%b eop=%b data=%h expected sop=%b eop=%b data=%h",
                   pix_sop, pix_eop, pix_data, e[CW+1], e[CW], e[CW-1:0]);
        else passed++;
      end
    end
    if (frame_done === 1'b1) frames++;
  endtask

  task automatic check_budget(input string name, input int cyc, input int limit);
    total++;
    if (cyc >= limit) $display("FAIL %s: cycle budget %0d expired", name, limit);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; hit_i = '1; colour_i = '1; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (xpixel_check !== '1) $display("FAIL rst_x: got %h expected all-ones", xpixel_check); else passed++;
    total++; if (ypixel_check !== '1) $display("FAIL rst_y: got %h expected all-ones", ypixel_check); else passed++;
    total++; if (pix_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", pix_valid); else passed++;
    total++; if (pix_data !== '0) $display("FAIL rst_data: got %h expected 0", pix_data); else passed++;
    total++; if ({pix_sop, pix_eop} !== 2'b00) $display("FAIL rst_sop_eop: got %b%b expected 00", pix_sop, pix_eop); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", frame_done); else passed++;
    total++; if (dup_err !== 1'b0) $display("FAIL rst_dup_err: got %b expected 0", dup_err); else passed++;
    total++; if (fsm_state !== ST_IDLE) $display("FAIL rst_state: got %0d expected %0d", fsm_state, ST_IDLE); else passed++;
`ifdef COMBINATOR_TIMEOUT_EN
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); else passed++;
`endif
    hit_i = '0; colour_i = '0;
  endtask

  task automatic test_full_frame();
    int cyc;
    run = 1'b1;
    do_reset();
    cyc = 0;
    while (frames < 1 && cyc < 200) begin step(1'b1); cyc++; end
    check_budget("full_frame_wait", cyc, 200);
    total++; if (beats != FW * FH) $display("FAIL frame_beats: got %0d expected %0d", beats, FW * FH); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL frame_leftover: got %0d expected 0", exp_q.size()); else passed++;
    cyc = 0;
    while (!req_pending && cyc < 20) begin step(1'b1); cyc++; end
    check_budget("restart_wait", cyc, 20);
    total++;
    if (last_req_x !== '0 || last_req_y !== '0)
      $display("FAIL restart_coord: got (%0d,%0d) expected (0,0)", last_req_x, last_req_y);
    else passed++;
    cyc = 0;
    while (beats < FW * FH + 2 && cyc < 50) begin step(1'b1); cyc++; end
    check_budget("second_frame_wait", cyc, 50);
    total++; if (frames != 1) $display("FAIL frame_done_count: got %0d expected 1", frames); else passed++;
  endtask

  task automatic test_backpressure();
    int cyc, n;
    run = 1'b1;
    do_reset();
    cyc = 0;
    while (pix_valid !== 1'b1 && cyc < 50) begin step(1'b0); cyc++; end
    check_budget("bp_first_beat", cyc, 50);
    n = issues;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 24'h000000 || pix_sop !== 1'b1)
        $display("FAIL bp_hold: got valid=%b data=%h sop=%b expected 1/000000/1", pix_valid, pix_data, pix_sop);
      else passed++;
    end
    total++; if (issues != n) $display("FAIL bp_no_issue: got %0d issues expected %0d", issues, n); else passed++;
    cyc = 0;
    while (beats < FW * FH && cyc < 200) begin step(1'b1); cyc++; end
    check_budget("bp_resume", cyc, 200);
    total++; if (frames != 1) $display("FAIL bp_frame_done: got %0d expected 1", frames); else passed++;
  endtask

  task automatic test_miss();
    int cyc;
    run = 1'b1;
    do_reset();
    target_idx = 1; target_misses = 3; target_colour = 24'hABCDEF; target_lane = 1;
    cyc = 0;
    while (beats < 2 && cyc < 100) begin step(1'b1); cyc++; end
    check_budget("miss_wait", cyc, 100);
    total++; if (target_issues != 4) $display("FAIL miss_issue_count: got %0d expected 4", target_issues); else passed++;
    total++; if (last_data !== 24'hABCDEF) $display("FAIL miss_data: got %h expected abcdef", last_data); else passed++;
    total++; if (dup_err !== 1'b0) $display("FAIL miss_dup_err: got %b expected 0", dup_err); else passed++;
  endtask

  task automatic test_double_hit();
    int cyc;
    run = 1'b1;
    do_reset();
    target_idx = 0; target_double = 1; target_lane = 0;
    target_colour = 24'h111111; target_colour2 = 24'h222222;
    cyc = 0;
    while (beats < 1 && cyc < 50) begin step(1'b1); cyc++; end
    check_budget("dbl_wait", cyc, 50);
    total++; if (last_data !== 24'h111111) $display("FAIL dbl_data: got %h expected 111111", last_data); else passed++;
    total++; if (dup_err !== 1'b1) $display("FAIL dbl_dup_err: got %b expected 1", dup_err); else passed++;
    cyc = 0;
    while (beats < 4 && cyc < 50) begin step(1'b1); cyc++; end
    check_budget("dbl_more", cyc, 50);
    total++; if (dup_err !== 1'b1) $display("FAIL dbl_sticky: got %b expected 1", dup_err); else passed++;
  endtask

  task automatic test_hold();
    int cyc;
    run = 1'b0;
    do_reset();
    repeat (5) step(1'b1);
    total++; if (issues != 0) $display("FAIL hold_issues: got %0d expected 0", issues); else passed++;
    @(posedge clk);
    #1 hit_i = 2'b01;
    step(1'b1);
    total++; if (dup_err !== 1'b1) $display("FAIL stray_hit_dup_err: got %b expected 1", dup_err); else passed++;
    total++; if (pix_valid !== 1'b0) $display("FAIL stray_hit_valid: got %b expected 0", pix_valid); else passed++;
    run = 1'b1;
    cyc = 0;
    while (beats < 2 && cyc < 50) begin step(1'b1); cyc++; end
    check_budget("hold_resume", cyc, 50);
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    run = 1'b1;
    do_reset();
    cyc = 0;
    while (!(next_idx == 7 && pix_valid === 1'b1) && cyc < 100) begin
      step(next_idx < 7);
      cyc++;
    end
    check_budget("mid_wait", cyc, 100);
    total++; if (pix_data !== 24'h000012) $display("FAIL mid_pending: got %h expected 000012", pix_data); else passed++;
    @(posedge clk);
    #1 reset = 1'b1; hit_i = '0; colour_i = '0;
    @(posedge clk);
    #1;
    total++; if (pix_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", pix_valid); else passed++;
    reset = 1'b0;
    model_clear();
    cyc = 0;
    while (issues < 1 && cyc < 20) begin step(1'b1); cyc++; end
    check_budget("mid_restart", cyc, 20);
    total++;
    if (last_req_x !== '0 || last_req_y !== '0)
      $display("FAIL mid_restart_coord: got (%0d,%0d) expected (0,0)", last_req_x, last_req_y);
    else passed++;
  endtask

  task automatic test_random();
    int cyc;
    run = 1'b1;
    do_reset();
    rand_colour = 1; rand_miss_pct = 20;
    cyc = 0;
    while (beats < 2 * FW * FH && cyc < 2000) begin
      step($urandom_range(0, 3) != 0);
      cyc++;
    end
    check_budget("rand_wait", cyc, 2000);
    total++; if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); else passed++;
    total++; if (frames != 2) $display("FAIL rand_frames: got %0d expected 2", frames); else passed++;
    total++; if (dup_err !== 1'b0) $display("FAIL rand_dup_err: got %b expected 0", dup_err); else passed++;
  endtask

`ifdef COMBINATOR_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    run = 1'b1;
    do_reset();
    target_idx = 0; target_misses = 1000;
    cyc = 0;
    while (beats < 1 && cyc < 100) begin step(1'b1); cyc++; end
    check_budget("tmo_wait", cyc, 100);
    total++; if (target_issues != TB_TIMEOUT) $display("FAIL tmo_issues: got %0d expected %0d", target_issues, TB_TIMEOUT); else passed++;
    total++; if (last_data !== 24'h000000) $display("FAIL tmo_data: got %h expected 000000", last_data); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL tmo_err: got %b expected 1", timeout_err); else passed++;
    cyc = 0;
    while (issues < TB_TIMEOUT + 1 && cyc < 20) begin step(1'b1); cyc++; end
    check_budget("tmo_next", cyc, 20);
    total++;
    if (last_req_x !== PW'(1) || last_req_y !== '0)
      $display("FAIL tmo_next_coord: got (%0d,%0d) expected (1,0)", last_req_x, last_req_y);
    else passed++;
  endtask
`endif

  initial begin
    run = 1'b0; reset = 1'b1; pix_ready = 1'b0; hit_i = '0; colour_i = '0;
    model_clear();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_miss();
    test_double_hit();
    test_hold();
    test_reset_mid_frame();
    test_random();
`ifdef COMBINATOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
